// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port, with a registered write stage
// and a pending-write scoreboard used by decode to stall reads of in-flight registers.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_sel,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we,
    output logic [4:0]           wsel,
    output logic [31:0]          data,
    input  logic [4:0]           r1sel,
    input  logic [4:0]           r2sel,
    output logic                 r1_stall,
    output logic                 r2_stall,
    output logic [31:0]          pend_mask
);

    localparam int unsigned LW = $clog2(NREQ);

    logic [LW-1:0] last_q, last_d;
    logic [LW-1:0] gnt_idx;
    logic          gnt_found;
    logic          hs;
    logic [4:0]    gnt_sel;
    logic [31:0]   gnt_data;

    logic          we_q, we_d;
    logic [4:0]    wsel_q, wsel_d;
    logic [31:0]   data_q, data_d;

    // First valid requester after the last grant, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = (int'(last_q) + k) % int'(NREQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = LW'(idx);
            end
        end
    end

    always_comb begin
        hs        = gnt_found && !reset;
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
        gnt_sel  = req_sel[5*int'(gnt_idx) +: 5];
        gnt_data = req_data[32*int'(gnt_idx) +: 32];
    end

    always_comb begin
        we_d   = 1'b0;
        wsel_d = wsel_q;
        data_d = data_q;
        last_d = last_q;
        if (hs) begin
            // Writes to r0 are consumed but never reach the register file.
            we_d   = (gnt_sel != 5'd0);
            wsel_d = gnt_sel;
            data_d = gnt_data;
            last_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            wsel_q <= 5'd0;
            data_q <= 32'd0;
            last_q <= LW'(NREQ - 1);
        end else begin
            we_q   <= we_d;
            wsel_q <= wsel_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    // Pending = waiting in a requester, or sitting in the output stage not yet committed.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (req_valid[i]) begin
                pend_mask[req_sel[5*i +: 5]] = 1'b1;
            end
        end
        if (we_q) begin
            pend_mask[wsel_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign we       = we_q;
    assign wsel     = wsel_q;
    assign data     = data_q;
    assign r1_stall = pend_mask[r1sel];
    assign r2_stall = pend_mask[r2sel];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus queues expected grants and writes,
// a negedge monitor pops and compares whenever the DUT grants or writes.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] dat;
    } wr_t;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [5*NREQ-1:0] req_sel;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              we;
    logic [4:0]        wsel;
    logic [31:0]       data;
    logic [4:0]        r1sel;
    logic [4:0]        r2sel;
    logic              r1_stall;
    logic              r2_stall;
    logic [31:0]       pend_mask;

    int  checks = 0;
    int  errors = 0;
    int  exp_g[$];
    wr_t exp_w[$];
    int  mon_g;
    wr_t mon_w;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we        (we),
        .wsel      (wsel),
        .data      (data),
        .r1sel     (r1sel),
        .r2sel     (r2sel),
        .r1_stall  (r1_stall),
        .r2_stall  (r2_stall),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] s,
                           input logic [31:0] d);
        req_valid[i]         = v;
        req_sel[5*i +: 5]    = s;
        req_data[32*i +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push_w(input logic [4:0] s, input logic [31:0] d);
        wr_t e;
        e.sel = s;
        e.dat = d;
        exp_w.push_back(e);
    endtask

    // Monitor: every grant and every register-file write must match the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (req_ready != '0) begin
                if (exp_g.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant: got req_ready %b expected no grant", req_ready);
                end else begin
                    mon_g = exp_g.pop_front();
                    check("grant", 32'(req_ready), 32'(1) << mon_g);
                end
            end
            if (we) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write: got write r%0d=%h expected no write", wsel, data);
                end else begin
                    mon_w = exp_w.pop_front();
                    check("wsel", 32'(wsel), 32'(mon_w.sel));
                    check("data", data, mon_w.dat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_sel   = '0;
        req_data  = '0;
        r1sel     = 5'd0;
        r2sel     = 5'd0;
        step();
        // During reset: no grant, but a valid requester still marks its register pending.
        set_req(0, 1'b1, 5'd3, 32'h1111);
        #1;
        check("rst ready", 32'(req_ready), 32'h0);
        check("rst pend", pend_mask, 32'h8);
        check("rst we", 32'(we), 32'h0);
        check("rst wsel", 32'(wsel), 32'h0);
        check("rst data", data, 32'h0);
        set_req(0, 1'b0, 5'd0, 32'h0);
        step();
        reset = 1'b0;

        // Single requester 1
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        exp_g.push_back(1);
        push_w(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("t1 ready", 32'(req_ready), 32'h2);
        check("t1 pend0", pend_mask, 32'h20);
        step();
        set_req(1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("t1 we", 32'(we), 32'h1);
        check("t1 pend1", pend_mask, 32'h20);
        step();
        @(negedge clk);
        check("t1 pend2", pend_mask, 32'h0);
        check("t1 we off", 32'(we), 32'h0);

        // All three continuously valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'hC0DE0000 + i);
        for (int c = 0; c < 9; c++) begin
            exp_g.push_back(c % NREQ);
            push_w(5'((c % NREQ) + 1), 32'hC0DE0000 + (c % NREQ));
            @(negedge clk);
            if (c > 0) check("t2 we", 32'(we), 32'h1);
            step();
        end
        req_valid = '0;
        step();

        // Write to r0 is consumed without a register-file write
        do_reset();
        set_req(0, 1'b1, 5'd0, 32'h1234);
        set_req(1, 1'b1, 5'd4, 32'h55);
        exp_g.push_back(0);
        @(negedge clk);
        check("t3 ready", 32'(req_ready), 32'h1);
        check("t3 pend", pend_mask, 32'h10);
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        exp_g.push_back(1);
        push_w(5'd4, 32'h55);
        @(negedge clk);
        check("t3 we0", 32'(we), 32'h0);
        check("t3 data", data, 32'h1234);
        step();
        set_req(1, 1'b0, 5'd0, 32'h0);
        step();

        // Read stall on r31
        do_reset();
        r1sel = 5'd31;
        r2sel = 5'd30;
        set_req(2, 1'b1, 5'd31, 32'h31);
        exp_g.push_back(2);
        push_w(5'd31, 32'h31);
        @(negedge clk);
        check("t4 r1 stall a", 32'(r1_stall), 32'h1);
        check("t4 r2 stall a", 32'(r2_stall), 32'h0);
        step();
        set_req(2, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("t4 r1 stall b", 32'(r1_stall), 32'h1);
        check("t4 r2 stall b", 32'(r2_stall), 32'h0);
        step();
        @(negedge clk);
        check("t4 r1 stall c", 32'(r1_stall), 32'h0);
        r1sel = 5'd0;
        r2sel = 5'd0;

        // Asynchronous reset drops the write held in the output stage
        do_reset();
        set_req(2, 1'b1, 5'd7, 32'h77);
        exp_g.push_back(2);
        step();
        set_req(2, 1'b0, 5'd0, 32'h0);
        check("t5 we held", 32'(we), 32'h1);
        check("t5 wsel held", 32'(wsel), 32'h7);
        #2;
        reset = 1'b1;
        #1;
        check("t5 we dropped", 32'(we), 32'h0);
        check("t5 wsel cleared", 32'(wsel), 32'h0);
        step();
        reset = 1'b0;
        set_req(0, 1'b1, 5'd10, 32'hA0);
        set_req(1, 1'b1, 5'd11, 32'hB0);
        exp_g.push_back(0);
        push_w(5'd10, 32'hA0);
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        exp_g.push_back(1);
        push_w(5'd11, 32'hB0);
        step();
        set_req(1, 1'b0, 5'd0, 32'h0);
        step();

        // Two requesters hitting the same register land in grant order
        do_reset();
        set_req(0, 1'b1, 5'd9, 32'hA);
        set_req(1, 1'b1, 5'd9, 32'hB);
        exp_g.push_back(0);
        push_w(5'd9, 32'hA);
        @(negedge clk);
        check("t6 pend a", 32'(pend_mask[9]), 32'h1);
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        exp_g.push_back(1);
        push_w(5'd9, 32'hB);
        @(negedge clk);
        check("t6 pend b", 32'(pend_mask[9]), 32'h1);
        step();
        set_req(1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("t6 pend c", 32'(pend_mask[9]), 32'h1);
        step();
        @(negedge clk);
        check("t6 pend d", 32'(pend_mask[9]), 32'h0);

        step();
        step();
        check("grants drained", 32'(exp_g.size()), 32'h0);
        check("writes drained", 32'(exp_w.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
